// File: rtl/keen_instruction_fetch.sv
// Instruction fetch front end: PC generation, in-order memory requests with a
// credit limit, a small response FIFO and a valid/ready stream to the decoder.
module keen_instruction_fetch #(
  parameter int              XLEN         = 32,
  parameter int              ILEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              DEPTH        = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_target,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [XLEN-1:0] o_mem_req_addr,
  input  logic            i_mem_rsp_valid,
  input  logic [ILEN-1:0] i_mem_rsp_data,
  input  logic            i_mem_rsp_error,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [ILEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_inst_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_pc;
  logic [ILEN-1:0] r_fifo_inst  [DEPTH];
  logic [XLEN-1:0] r_fifo_pc    [DEPTH];
  logic            r_fifo_fault [DEPTH];
  logic [XLEN-1:0] r_pend_pc    [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr, r_pend_wr, r_pend_rd;
  logic [CW-1:0]   r_count, r_outstanding, r_drop;
  logic            r_inst_valid;
  logic [ILEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_inst_fault;

  logic            w_credit_ok, w_req_valid, w_req_fire;
  logic            w_rsp_fire, w_rsp_keep, w_pop;
  logic [ILEN-1:0] w_push_inst;
  logic [XLEN-1:0] w_push_pc;
  logic [CW-1:0]   w_count_after_pop, w_count_next;
  logic [AW-1:0]   w_rd_ptr_next;
  logic [ILEN-1:0] w_head_inst;
  logic [XLEN-1:0] w_head_pc;
  logic            w_head_fault;

  // Requests are gated by rst_n directly so the bus goes quiet the moment reset asserts.
  assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW + 1)'(DEPTH);
  assign w_req_valid = rst_n & w_credit_ok & ~i_redirect_valid;
  assign w_req_fire  = w_req_valid & i_mem_req_ready;

  assign w_rsp_fire  = i_mem_rsp_valid & (r_outstanding != '0);
  assign w_rsp_keep  = w_rsp_fire & (r_drop == '0) & ~i_redirect_valid;
  assign w_pop       = r_inst_valid & i_inst_ready & ~i_redirect_valid;
  assign w_push_inst = i_mem_rsp_error ? '0 : i_mem_rsp_data;
  assign w_push_pc   = r_pend_pc[r_pend_rd];

  assign w_count_after_pop = r_count - CW'(w_pop);
  assign w_count_next      = w_count_after_pop + CW'(w_rsp_keep);
  assign w_rd_ptr_next     = r_rd_ptr + AW'(w_pop);

  // Next head: the incoming response bypasses storage when nothing else remains.
  always_comb begin
    w_head_inst  = w_push_inst;
    w_head_pc    = w_push_pc;
    w_head_fault = i_mem_rsp_error;
    if (w_count_after_pop != '0) begin
      w_head_inst  = r_fifo_inst[w_rd_ptr_next];
      w_head_pc    = r_fifo_pc[w_rd_ptr_next];
      w_head_fault = r_fifo_fault[w_rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (w_rsp_keep) begin
      r_fifo_inst[r_wr_ptr]  <= w_push_inst;
      r_fifo_pc[r_wr_ptr]    <= w_push_pc;
      r_fifo_fault[r_wr_ptr] <= i_mem_rsp_error;
    end
    if (w_req_fire) begin
      r_pend_pc[r_pend_wr] <= r_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_VECTOR & ~XLEN'(3);
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pend_wr     <= '0;
      r_pend_rd     <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_inst_valid  <= 1'b0;
      r_inst        <= '0;
      r_inst_pc     <= '0;
      r_inst_fault  <= 1'b0;
    end else begin
      if (w_req_fire) r_pend_wr <= r_pend_wr + 1'b1;
      if (w_rsp_fire) r_pend_rd <= r_pend_rd + 1'b1;
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_fire);
      if (i_redirect_valid) begin
        // Every fetch still in flight, minus one retiring now, belongs to the old path.
        r_pc         <= i_redirect_target & ~XLEN'(3);
        r_drop       <= r_outstanding - CW'(w_rsp_fire);
        r_count      <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_inst_valid <= 1'b0;
      end else begin
        if (w_req_fire) r_pc <= r_pc + XLEN'(4);
        if (w_rsp_fire && (r_drop != '0)) r_drop <= r_drop - 1'b1;
        if (w_rsp_keep) r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rd_ptr     <= w_rd_ptr_next;
        r_count      <= w_count_next;
        r_inst_valid <= (w_count_next != '0);
        if (w_count_next != '0) begin
          r_inst       <= w_head_inst;
          r_inst_pc    <= w_head_pc;
          r_inst_fault <= w_head_fault;
        end
      end
    end
  end

  assign o_mem_req_valid = w_req_valid;
  assign o_mem_req_addr  = r_pc;
  assign o_inst_valid    = r_inst_valid;
  assign o_inst          = r_inst;
  assign o_inst_pc       = r_inst_pc;
  assign o_inst_fault    = r_inst_fault;

  rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    i_mem_rsp_valid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_keen_instruction_fetch.sv
// Bench for keen_instruction_fetch: in-order memory model plus a queue-based
// model of the fetched instruction stream, directed scenarios and a random run.
module tb_keen_instruction_fetch;
  localparam int          DEPTH        = 2;
  localparam logic [31:0] RESET_VECTOR = 32'h0;

  logic        clk, rst_n;
  logic        i_redirect_valid, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_error, i_inst_ready;
  logic [31:0] i_redirect_target, i_mem_rsp_data;
  logic        o_mem_req_valid, o_inst_valid, o_inst_fault;
  logic [31:0] o_mem_req_addr, o_inst, o_inst_pc;

  keen_instruction_fetch #(.XLEN(32), .ILEN(32), .RESET_VECTOR(RESET_VECTOR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_redirect_valid(i_redirect_valid), .i_redirect_target(i_redirect_target),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data), .i_mem_rsp_error(i_mem_rsp_error),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready), .o_inst(o_inst),
    .o_inst_pc(o_inst_pc), .o_inst_fault(o_inst_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } ent_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  req_t        mem_q[$];
  ent_t        m_fifo[$];
  int          m_out, m_drop;
  logic [31:0] exp_req_pc, exp_stream_pc, err_addr;
  logic        rand_err;

  logic        k_req_ready, k_inst_ready, k_redirect;
  logic [31:0] k_target;
  int          k_delay;

  logic        obs_req_valid, obs_hs, obs_rsp, obs_pop, obs_inst_valid, obs_fault;
  logic [31:0] obs_req_addr, obs_inst, obs_inst_pc;
  logic        exp_req_valid, exp_inst_valid;
  logic [31:0] exp_req_addr, exp_pop_pc;
  ent_t        exp_head;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == err_addr) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    logic [31:0] d;
    d = mem_data(a);
    return (a == err_addr) || (rand_err && (d[2:0] == 3'b000));
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    mem_q.delete();
    m_fifo.delete();
    m_out = 0;
    m_drop = 0;
    exp_req_pc = RESET_VECTOR;
    exp_stream_pc = RESET_VECTOR;
    err_addr = 32'h1;
    rand_err = 1'b0;
    k_req_ready = 1'b1; k_inst_ready = 1'b1; k_redirect = 1'b0; k_target = '0; k_delay = 1;
    i_redirect_valid = 1'b0; i_redirect_target = '0; i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0; i_mem_rsp_error = 1'b0; i_inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  // One bus cycle: drive knobs, sample outputs, then advance the memory and stream model.
  task automatic tick();
    req_t r;
    ent_t e;
    logic m_pop;
    obs_rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    i_mem_req_ready   = k_req_ready;
    i_inst_ready      = k_inst_ready;
    i_redirect_valid  = k_redirect;
    i_redirect_target = k_target;
    i_mem_rsp_valid   = obs_rsp;
    if (obs_rsp) begin
      i_mem_rsp_data  = mem_data(mem_q[0].addr);
      i_mem_rsp_error = mem_err(mem_q[0].addr);
    end else begin
      i_mem_rsp_data  = $urandom;
      i_mem_rsp_error = 1'($urandom_range(0, 1));
    end
    exp_req_valid  = ((m_fifo.size() + m_out) < DEPTH) && !k_redirect;
    exp_req_addr   = exp_req_pc;
    exp_inst_valid = (m_fifo.size() != 0);
    if (exp_inst_valid) exp_head = m_fifo[0];
    exp_pop_pc = exp_stream_pc;
    #1;
    obs_req_valid  = o_mem_req_valid;
    obs_req_addr   = o_mem_req_addr;
    obs_inst_valid = o_inst_valid;
    obs_inst       = o_inst;
    obs_inst_pc    = o_inst_pc;
    obs_fault      = o_inst_fault;
    obs_hs  = obs_req_valid && k_req_ready;
    obs_pop = obs_inst_valid && k_inst_ready && !k_redirect;
    m_pop   = obs_pop && exp_inst_valid;
    @(posedge clk);
    if (k_redirect) begin
      m_drop = m_out - (obs_rsp ? 1 : 0);
      m_fifo.delete();
      exp_req_pc = k_target & ~32'h3;
      exp_stream_pc = exp_req_pc;
    end else begin
      if (m_pop) begin
        void'(m_fifo.pop_front());
        exp_stream_pc += 4;
      end
      if (obs_hs) exp_req_pc += 4;
    end
    if (obs_rsp) begin
      r = mem_q.pop_front();
      m_out--;
      if (!k_redirect) begin
        if (m_drop > 0) m_drop--;
        else begin
          e.pc = r.addr;
          e.err = mem_err(r.addr);
          e.data = e.err ? 32'h0 : mem_data(r.addr);
          m_fifo.push_back(e);
        end
      end
    end
    if (obs_hs) begin
      mem_q.push_back('{addr: obs_req_addr, due: cyc + k_delay});
      m_out++;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", o_mem_req_valid); end
    checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", o_inst_valid); end
    checks++; if (o_inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", o_inst); end
    checks++; if (o_inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst_pc got=%h exp=0", o_inst_pc); end
    checks++; if (o_inst_fault !== 1'b0) begin failures++; $display("FAIL reset_inst_fault got=%b exp=0", o_inst_fault); end
    checks++; if (o_mem_req_addr !== RESET_VECTOR) begin failures++; $display("FAIL reset_req_addr got=%h exp=%h", o_mem_req_addr, RESET_VECTOR); end
    do_reset();
    checks++; if (o_mem_req_valid !== 1'b1) begin failures++; $display("FAIL reset_first_req got=%b exp=1", o_mem_req_valid); end
  endtask

  task automatic test_sequential();
    int n_hs = 0;
    int n_pop = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (obs_hs) begin
        checks++; if (obs_req_addr !== RESET_VECTOR + 32'(4 * n_hs)) begin failures++; $display("FAIL seq_req_addr got=%h exp=%h", obs_req_addr, RESET_VECTOR + 32'(4 * n_hs)); end
        n_hs++;
      end
      if (obs_pop) begin
        checks++; if (obs_inst_pc !== RESET_VECTOR + 32'(4 * n_pop)) begin failures++; $display("FAIL seq_inst_pc got=%h exp=%h", obs_inst_pc, RESET_VECTOR + 32'(4 * n_pop)); end
        n_pop++;
      end
    end
    checks++; if (n_pop < 8) begin failures++; $display("FAIL seq_throughput got=%0d exp>=8", n_pop); end
  endtask

  task automatic test_backpressure();
    int n_hs = 0;
    int n_pop = 0;
    logic [31:0] pops[2];
    logic [31:0] first_hs = 32'hFFFF_FFFF;
    do_reset();
    k_inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_hs) n_hs++;
      if (i >= 3) begin
        checks++; if (obs_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_held got=%b exp=0", obs_req_valid); end
      end
      if (obs_inst_valid) begin
        checks++; if (obs_inst_pc !== 32'h0 || obs_inst !== mem_data(32'h0)) begin failures++; $display("FAIL bp_head_stable got=%h/%h exp=0/%h", obs_inst_pc, obs_inst, mem_data(32'h0)); end
      end
    end
    checks++; if (n_hs != DEPTH) begin failures++; $display("FAIL bp_req_count got=%0d exp=%0d", n_hs, DEPTH); end
    k_inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_pop && n_pop < 2) begin pops[n_pop] = obs_inst_pc; n_pop++; end
      if (obs_hs && first_hs == 32'hFFFF_FFFF) first_hs = obs_req_addr;
    end
    checks++; if (n_pop != 2 || pops[0] !== 32'h0 || pops[1] !== 32'h4) begin failures++; $display("FAIL bp_drain got=%0d:%h,%h exp=2:0,4", n_pop, pops[0], pops[1]); end
    checks++; if (first_hs !== 32'h8) begin failures++; $display("FAIL bp_resume got=%h exp=8", first_hs); end
  endtask

  task automatic test_redirect_outstanding();
    int n_hs = 0;
    logic seen = 1'b0;
    logic [31:0] first_hs = 32'hFFFF_FFFF;
    do_reset();
    k_delay = 5;
    repeat (2) begin tick(); if (obs_hs) n_hs++; end
    checks++; if (n_hs != 2) begin failures++; $display("FAIL ro_setup got=%0d exp=2", n_hs); end
    k_redirect = 1'b1; k_target = 32'h1003;
    tick();
    checks++; if (obs_req_valid !== 1'b0) begin failures++; $display("FAIL ro_req_in_redirect got=%b exp=0", obs_req_valid); end
    k_redirect = 1'b0; k_delay = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (obs_hs && first_hs == 32'hFFFF_FFFF) first_hs = obs_req_addr;
      if (obs_inst_valid && !seen) begin
        seen = 1'b1;
        checks++; if (obs_inst_pc !== 32'h1000) begin failures++; $display("FAIL ro_first_pc got=%h exp=1000", obs_inst_pc); end
      end
      if (obs_inst_valid) begin
        checks++; if (obs_inst_pc < 32'h1000 || obs_inst_pc >= 32'h1100) begin failures++; $display("FAIL ro_stale_pc got=%h exp=1000..10ff", obs_inst_pc); end
      end
    end
    checks++; if (first_hs !== 32'h1000) begin failures++; $display("FAIL ro_target_req got=%h exp=1000", first_hs); end
    checks++; if (!seen) begin failures++; $display("FAIL ro_no_output got=0 exp=1"); end
  endtask

  task automatic test_redirect_same_cycle();
    int n = 0;
    logic seen = 1'b0;
    do_reset();
    while (n < 20 && !(mem_q.size() > 0 && mem_q[0].due <= cyc && m_fifo.size() != 0)) begin
      tick();
      n++;
    end
    checks++; if (n >= 20) begin failures++; $display("FAIL sc_setup_timeout got=%0d exp<20", n); end
    k_redirect = 1'b1; k_target = 32'h2000;
    tick();
    checks++; if (!(obs_rsp && obs_inst_valid)) begin failures++; $display("FAIL sc_collision got=%b%b exp=11", obs_rsp, obs_inst_valid); end
    k_redirect = 1'b0;
    tick();
    checks++; if (obs_inst_valid !== 1'b0) begin failures++; $display("FAIL sc_flushed got=%b exp=0", obs_inst_valid); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_inst_valid) begin
        checks++; if (obs_inst_pc < 32'h2000 || obs_inst_pc >= 32'h2100) begin failures++; $display("FAIL sc_stale_pc got=%h exp=2000..20ff", obs_inst_pc); end
        if (!seen) begin
          seen = 1'b1;
          checks++; if (obs_inst_pc !== 32'h2000) begin failures++; $display("FAIL sc_first_pc got=%h exp=2000", obs_inst_pc); end
        end
      end
    end
  endtask

  task automatic test_fault();
    logic seen8 = 1'b0;
    logic seenc = 1'b0;
    do_reset();
    err_addr = 32'h8;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (obs_pop && obs_inst_pc === 32'h8) begin
        seen8 = 1'b1;
        checks++; if (obs_fault !== 1'b1 || obs_inst !== 32'h0) begin failures++; $display("FAIL fault_entry got=%b/%h exp=1/0", obs_fault, obs_inst); end
      end
      if (obs_pop && obs_inst_pc === 32'hC) begin
        seenc = 1'b1;
        checks++; if (obs_fault !== 1'b0 || obs_inst !== mem_data(32'hC)) begin failures++; $display("FAIL fault_next got=%b/%h exp=0/%h", obs_fault, obs_inst, mem_data(32'hC)); end
      end
    end
    checks++; if (!(seen8 && seenc)) begin failures++; $display("FAIL fault_seen got=%b%b exp=11", seen8, seenc); end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] hs[2];
    int n_hs = 0;
    int n = 0;
    do_reset();
    k_redirect = 1'b1; k_target = 32'hFFFF_FFFC;
    tick();
    k_redirect = 1'b0; k_inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_hs && n_hs < 2) begin hs[n_hs] = obs_req_addr; n_hs++; end
    end
    checks++; if (n_hs != 2 || hs[0] !== 32'hFFFF_FFFC || hs[1] !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%0d:%h,%h exp=2:fffffffc,0", n_hs, hs[0], hs[1]); end
    while (n < 10 && !obs_inst_valid) begin tick(); n++; end
    checks++; if (!obs_inst_valid) begin failures++; $display("FAIL wrap_buffered got=0 exp=1"); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL async_rst_inst_valid got=%b exp=0", o_inst_valid); end
    checks++; if (o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL async_rst_req_valid got=%b exp=0", o_mem_req_valid); end
    do_reset();
    tick();
    checks++; if (!obs_hs || obs_req_addr !== RESET_VECTOR) begin failures++; $display("FAIL restart_addr got=%b/%h exp=1/%h", obs_hs, obs_req_addr, RESET_VECTOR); end
  endtask

  task automatic test_random();
    do_reset();
    rand_err = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      k_req_ready  = ($urandom_range(0, 3) != 0);
      k_inst_ready = ($urandom_range(0, 3) != 0);
      k_redirect   = ($urandom_range(0, 39) == 0);
      k_target     = $urandom;
      k_delay      = $urandom_range(1, 4);
      tick();
      checks++; if (obs_req_valid !== exp_req_valid) begin failures++; $display("FAIL rnd_req_valid cyc=%0d got=%b exp=%b", cyc, obs_req_valid, exp_req_valid); end
      if (obs_hs) begin
        checks++; if (obs_req_addr !== exp_req_addr) begin failures++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, obs_req_addr, exp_req_addr); end
      end
      checks++; if (obs_inst_valid !== exp_inst_valid) begin failures++; $display("FAIL rnd_inst_valid cyc=%0d got=%b exp=%b", cyc, obs_inst_valid, exp_inst_valid); end
      if (obs_inst_valid && exp_inst_valid) begin
        checks++;
        if (obs_inst_pc !== exp_head.pc || obs_inst !== exp_head.data || obs_fault !== exp_head.err) begin
          failures++;
          $display("FAIL rnd_head cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, obs_inst_pc, obs_inst, obs_fault, exp_head.pc, exp_head.data, exp_head.err);
        end
      end
      if (obs_pop) begin
        checks++; if (obs_inst_pc !== exp_pop_pc) begin failures++; $display("FAIL rnd_stream_pc cyc=%0d got=%h exp=%h", cyc, obs_inst_pc, exp_pop_pc); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    err_addr = 32'h1; rand_err = 1'b0;
    i_redirect_valid = 1'b0; i_redirect_target = '0; i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0; i_mem_rsp_error = 1'b0; i_inst_ready = 1'b0;
    #2;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_fault();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
